// File: rtl/dmem_arb_pkg.sv
// Shared types and widths for the DataMemory two-port arbiter.
package dmem_arb_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef logic port_id_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } acc_req_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side handshakes plus the DataMemory port of the arbiter.
interface dmem_arbiter_if;
    import dmem_arb_pkg::*;

    logic              req0,   req1;
    logic              we0,    we1;
    logic [ADDR_W-1:0] addr0,  addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic              gnt0,   gnt1;
    logic              done0,  done1;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        output gnt0, gnt1, done0, done1, rdata, mem_addr, mem_we, mem_wdata
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        input  gnt0, gnt1, done0, done1, rdata, mem_addr, mem_we, mem_wdata
    );

endinterface

// File: rtl/dmem_arb_pick.sv
// Winner selection between the two ports.
// DMEM_ARB_RR_EN defined: round-robin on ties; undefined: port 0 has fixed priority.
module dmem_arb_pick
    import dmem_arb_pkg::*;
(
    input  logic     req0,
    input  logic     req1,
    input  port_id_t last_gnt,
    output port_id_t win_c,
    output logic     valid_c
);

    assign valid_c = req0 | req1;

`ifdef DMEM_ARB_RR_EN
    // On a tie the port that did not win last time goes next.
    assign win_c = (req0 & req1) ? port_id_t'(~last_gnt) : port_id_t'(~req0);
`else
    logic unused_last_gnt;
    assign unused_last_gnt = last_gnt;
    assign win_c = port_id_t'(~req0);
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Shares single-ported DataMemory between CPU (port 0) and a secondary requester (port 1).
// Tie-break policy selected by DMEM_ARB_RR_EN (round-robin when defined).
module dmem_arbiter
    import dmem_arb_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);

    state_t            state_q, state_d;
    port_id_t          port_q;
    port_id_t          last_gnt;
    port_id_t          win;
    logic              win_v;
    logic              take;
    acc_req_t          cur;
    acc_req_t          lat_q;
    logic              we_q;
    logic              gnt0_q, gnt1_q, done0_q, done1_q;
    logic              gnt0_d, gnt1_d, done0_d, done1_d;
    logic              rd_cap;
    logic [DATA_W-1:0] rdata_q;

    dmem_arb_pick u_pick (
        .req0     (bus.req0),
        .req1     (bus.req1),
        .last_gnt (last_gnt),
        .win_c    (win),
        .valid_c  (win_v)
    );

    assign cur = win ? acc_req_t'{we: bus.we1, addr: bus.addr1, wdata: bus.wdata1}
                     : acc_req_t'{we: bus.we0, addr: bus.addr0, wdata: bus.wdata0};

    // Next state and next registered outputs.
    always_comb begin
        state_d = state_q;
        take    = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_v) begin
                    take    = 1'b1;
                    state_d = ACCESS;
                end
            end
            ACCESS: state_d = DONE;
            DONE: begin
                if (win_v) begin
                    take    = 1'b1;
                    state_d = ACCESS;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        gnt0_d  = take & (win == 1'b0);
        gnt1_d  = take & (win == 1'b1);
        done0_d = (state_q == ACCESS) & (port_q == 1'b0);
        done1_d = (state_q == ACCESS) & (port_q == 1'b1);
        rd_cap  = (state_q == ACCESS) & ~lat_q.we;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            port_q  <= 1'b0;
            lat_q   <= '0;
            we_q    <= 1'b0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= take & cur.we;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
            if (take) begin
                port_q <= win;
                lat_q  <= cur;
            end
            if (rd_cap) rdata_q <= bus.mem_rdata;
        end
    end

`ifdef DMEM_ARB_RR_EN
    // Reset to port 1 so port 0 takes the first tie.
    always_ff @(posedge clk) begin
        if (rst)       last_gnt <= 1'b1;
        else if (take) last_gnt <= win;
    end
`else
    assign last_gnt = 1'b1;
`endif

    // A write in flight is cancelled the moment reset is seen.
    assign bus.mem_we    = we_q & ~rst;
    assign bus.mem_addr  = lat_q.addr;
    assign bus.mem_wdata = lat_q.wdata;
    assign bus.gnt0      = gnt0_q;
    assign bus.gnt1      = gnt1_q;
    assign bus.done0     = done0_q;
    assign bus.done1     = done1_q;
    assign bus.rdata     = rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: vector table, directed corner cases, random traffic vs model.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_arbiter_if bus ();

    dmem_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int fails  = 0;
    logic mem_clr = 1'b1;
    logic chk_en  = 1'b0;

    // DataMemory: combinational read, write on clock edge.
    logic [DATA_W-1:0] dmem [0:(1<<ADDR_W)-1];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < (1<<ADDR_W); i++) dmem[i] <= '0;
        end else if (bus.mem_we) begin
            dmem[bus.mem_addr] <= bus.mem_wdata;
        end
    end
    assign bus.mem_rdata = dmem[bus.mem_addr];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level reference: one pending access, one finished access.
    logic              m_acc_v, m_fin_v, m_acc_p, m_fin_p, m_acc_we, m_last;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata, m_rdata;
    logic [DATA_W-1:0] ref_mem [0:(1<<ADDR_W)-1];

    function automatic logic model_pick(input logic r0, input logic r1, input logic last);
        if (r0 && r1) begin
`ifdef DMEM_ARB_RR_EN
            return !last;
`else
            return 1'b0;
`endif
        end
        return !r0;
    endfunction

    always @(posedge clk) begin
        if (mem_clr)
            for (int i = 0; i < (1<<ADDR_W); i++) ref_mem[i] <= '0;
        if (rst) begin
            m_acc_v <= 1'b0; m_fin_v <= 1'b0; m_acc_p <= 1'b0; m_fin_p <= 1'b0;
            m_acc_we <= 1'b0; m_rdata <= '0; m_addr <= '0; m_wdata <= '0; m_last <= 1'b1;
        end else begin
            m_fin_v <= m_acc_v;
            m_fin_p <= m_acc_p;
            if (m_acc_v) begin
                if (m_acc_we) ref_mem[m_addr] <= m_wdata;
                else          m_rdata <= ref_mem[m_addr];
                m_acc_v <= 1'b0;
            end else if (bus.req0 || bus.req1) begin
                m_acc_v  <= 1'b1;
                m_acc_p  <= model_pick(bus.req0, bus.req1, m_last);
                m_last   <= model_pick(bus.req0, bus.req1, m_last);
                m_acc_we <= model_pick(bus.req0, bus.req1, m_last) ? bus.we1 : bus.we0;
                m_addr   <= model_pick(bus.req0, bus.req1, m_last) ? bus.addr1 : bus.addr0;
                m_wdata  <= model_pick(bus.req0, bus.req1, m_last) ? bus.wdata1 : bus.wdata0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("m_gnt0",  bus.gnt0,  m_acc_v && !m_acc_p);
            check("m_gnt1",  bus.gnt1,  m_acc_v &&  m_acc_p);
            check("m_done0", bus.done0, m_fin_v && !m_fin_p);
            check("m_done1", bus.done1, m_fin_v &&  m_fin_p);
            check("m_mem_we", bus.mem_we, m_acc_v && m_acc_we && !rst);
            check("m_rdata", bus.rdata, m_rdata);
            check("m_mem_addr", 32'(bus.mem_addr), 32'(m_addr));
            check("m_mem_wdata", bus.mem_wdata, m_wdata);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input logic r, input logic we,
                           input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        if (p == 0) begin
            bus.req0 = r; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d;
        end else begin
            bus.req1 = r; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d;
        end
    endtask

    function automatic logic gnt_of(input int p);
        return (p == 1) ? bus.gnt1 : bus.gnt0;
    endfunction

    function automatic logic done_of(input int p);
        return (p == 1) ? bus.done1 : bus.done0;
    endfunction

    // Isolated access from IDLE: gnt + memory cycle, then done, then back to IDLE.
    task automatic single(input int p, input logic we, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] exp_rd);
        set_req(p, 1'b1, we, a, d);
        cyc();
        check("gnt_own",   gnt_of(p), 1'b1);
        check("gnt_other", gnt_of(1 - p), 1'b0);
        check("mem_we",    bus.mem_we, we);
        check("mem_addr",  32'(bus.mem_addr), 32'(a));
        if (we) check("mem_wdata", bus.mem_wdata, d);
        set_req(p, 1'b0, 1'b0, '0, '0);
        cyc();
        check("done_own",  done_of(p), 1'b1);
        check("done_other", done_of(1 - p), 1'b0);
        check("mem_we_done", bus.mem_we, 1'b0);
        check("rdata",     bus.rdata, exp_rd);
        cyc();
        check("done_clear", done_of(p), 1'b0);
    endtask

    typedef struct {
        int                port;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] exp_rd;
    } vec_t;

    vec_t vt [7];
    logic pend [2];
    int   exp_p;

    initial begin
        vt[0] = '{0, 1'b1, 16'd3,  32'd1023, 32'd0};
        vt[1] = '{0, 1'b0, 16'd3,  32'd0,    32'd1023};
        vt[2] = '{1, 1'b1, 16'd9,  32'd77,   32'd1023};
        vt[3] = '{1, 1'b0, 16'd9,  32'd0,    32'd77};
        vt[4] = '{0, 1'b0, 16'd0,  32'd0,    32'd0};
        vt[5] = '{1, 1'b1, 16'd9,  32'd78,   32'd0};
        vt[6] = '{1, 1'b0, 16'd9,  32'd0,    32'd78};

        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
        cyc();
        chk_en = 1'b1;
        cyc();
        mem_clr = 1'b0;
        rst = 1'b0;

        // Quiet after reset.
        for (int i = 0; i < 10; i++) begin
            cyc();
            check("idle_gnt",  32'({bus.gnt0, bus.gnt1}), 32'd0);
            check("idle_done", 32'({bus.done0, bus.done1}), 32'd0);
            check("idle_we",   bus.mem_we, 1'b0);
            check("idle_rdata", bus.rdata, 32'd0);
        end

        for (int i = 0; i < 7; i++)
            single(vt[i].port, vt[i].we, vt[i].addr, vt[i].wdata, vt[i].exp_rd);

        // Simultaneous: port 0 read 3, port 1 write 15; port 0 wins the tie in both builds.
        set_req(0, 1'b1, 1'b0, 16'd3, '0);
        set_req(1, 1'b1, 1'b1, 16'd15, 32'd2047);
        cyc();
        check("sim_gnt0", bus.gnt0, 1'b1);
        check("sim_gnt1", bus.gnt1, 1'b0);
        set_req(0, 1'b0, 1'b0, '0, '0);
        cyc();
        check("sim_done0", bus.done0, 1'b1);
        check("sim_rdata0", bus.rdata, 32'd1023);
        cyc();
        check("sim_gnt1b", bus.gnt1, 1'b1);
        check("sim_we1", bus.mem_we, 1'b1);
        check("sim_addr1", 32'(bus.mem_addr), 32'd15);
        set_req(1, 1'b0, 1'b0, '0, '0);
        cyc();
        check("sim_done1", bus.done1, 1'b1);
        check("sim_rdata_keep", bus.rdata, 32'd1023);
        cyc();
        single(1, 1'b0, 16'd15, '0, 32'd2047);

        // Both ports hold req for 8 accesses.
        set_req(0, 1'b1, 1'b0, 16'd3, '0);
        set_req(1, 1'b1, 1'b0, 16'd15, '0);
        for (int i = 0; i < 8; i++) begin
`ifdef DMEM_ARB_RR_EN
            exp_p = i % 2;
`else
            exp_p = 0;
`endif
            cyc();
            check("hold_gnt0", bus.gnt0, exp_p == 0);
            check("hold_gnt1", bus.gnt1, exp_p == 1);
            if (i == 7) begin
                set_req(0, 1'b0, 1'b0, '0, '0);
                set_req(1, 1'b0, 1'b0, '0, '0);
            end
            cyc();
            check("hold_done", done_of(exp_p), 1'b1);
            check("hold_rdata", bus.rdata, (exp_p == 1) ? 32'd2047 : 32'd1023);
        end
        cyc();

        // Back-to-back reads from port 0 with the second request raised in DONE.
        set_req(0, 1'b1, 1'b0, 16'd3, '0);
        cyc();
        set_req(0, 1'b0, 1'b0, '0, '0);
        cyc();
        check("b2b_done_a", bus.done0, 1'b1);
        check("b2b_rdata_a", bus.rdata, 32'd1023);
        set_req(0, 1'b1, 1'b0, 16'd15, '0);
        cyc();
        check("b2b_gnt_b", bus.gnt0, 1'b1);
        check("b2b_addr_b", 32'(bus.mem_addr), 32'd15);
        set_req(0, 1'b0, 1'b0, '0, '0);
        cyc();
        check("b2b_done_b", bus.done0, 1'b1);
        check("b2b_rdata_b", bus.rdata, 32'd2047);
        cyc();

        // Reset in ACCESS aborts the write.
        single(0, 1'b1, 16'd7, 32'd44, 32'd2047);
        set_req(0, 1'b1, 1'b1, 16'd7, 32'd55);
        cyc();
        rst = 1'b1;
        set_req(0, 1'b0, 1'b0, '0, '0);
        #1;
        check("abort_we", bus.mem_we, 1'b0);
        check("abort_gnt0", bus.gnt0, 1'b1);
        cyc();
        check("abort_done0", bus.done0, 1'b0);
        check("abort_gnt0_clr", bus.gnt0, 1'b0);
        rst = 1'b0;
        cyc();
        single(0, 1'b0, 16'd7, '0, 32'd44);

        // Reset in DONE: done still visible, pending request dropped.
        set_req(0, 1'b1, 1'b0, 16'd3, '0);
        cyc();
        set_req(0, 1'b0, 1'b0, '0, '0);
        cyc();
        rst = 1'b1;
        set_req(1, 1'b1, 1'b1, 16'd5, 32'd99);
        #1;
        check("rstdone_done0", bus.done0, 1'b1);
        check("rstdone_rdata", bus.rdata, 32'd1023);
        cyc();
        check("rstdone_gnt1", bus.gnt1, 1'b0);
        check("rstdone_done0_clr", bus.done0, 1'b0);
        check("rstdone_rdata_clr", bus.rdata, 32'd0);
        rst = 1'b0;
        set_req(1, 1'b0, 1'b0, '0, '0);
        cyc();
        single(1, 1'b0, 16'd5, '0, 32'd0);

        // Random traffic; each requester drops req once it sees its grant.
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        for (int n = 0; n < 600; n++) begin
            cyc();
            for (int p = 0; p < 2; p++) begin
                if (pend[p] && gnt_of(p)) begin
                    pend[p] = 1'b0;
                    set_req(p, 1'b0, 1'b0, '0, '0);
                end else if (!pend[p] && ($urandom_range(2) == 0)) begin
                    pend[p] = 1'b1;
                    set_req(p, 1'b1, 1'($urandom_range(1)), ADDR_W'($urandom_range(15)), $urandom);
                end
            end
        end
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
        repeat (4) cyc();
        @(negedge clk);
        chk_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
